mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
- Consumer of the free-running random value produced by the mole RNG.
- Turns that value into a pre-spawn delay and a hole index, then raises one mole and times its up-window.
- Judges player hits against timeout and keeps hit/miss tallies for the score/display logic.
- Sits between the RNG, the debounced button inputs and the LED/score blocks.

Parameters:
- CLKS_PER_MS, 50000, clock cycles per 1 ms tick (50 MHz clock).
- VALUE_W, 11, width of random_value in ms.
- N_HOLES, 4, number of holes; power of 2, at least 2.
- UP_BASE_MS, 1000, mole up-time at level 0, in ms.
- UP_STEP_MS, 200, up-time reduction per level step; must satisfy UP_BASE_MS > 3*UP_STEP_MS.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- reset, input, 1, synchronous, active-high.
- enable, input, 1, game running.
- level, input, 2, difficulty 0..3.
- random_value, input, VALUE_W, current RNG output in ms; may change every cycle.
- hit, input, N_HOLES, debounced button levels, one per hole.
- mole_on, output, N_HOLES, one-hot visible mole; all zero when no mole is up.
- hit_pulse, output, 1, one-cycle strobe on a successful hit.
- miss_pulse, output, 1, one-cycle strobe when a mole expires or is missed.
- hit_count, output, 8, saturating count of hits.
- miss_count, output, 8, saturating count of misses.

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE; all outputs 0; prescaler, delay and up counters cleared.
- ms tick:
  - Prescaler counts 0..CLKS_PER_MS-1 and cleared on every state change.
  - tick asserts when prescaler = CLKS_PER_MS-1, so every interval is an exact multiple of CLKS_PER_MS cycles.
- State IDLE:
  - mole_on=0.
  - If enable=1: sample random_value into the delay counter (value 0 treated as 1) and go to WAIT.
- State WAIT:
  - mole_on=0; hit is ignored.
  - Delay counter decrements on each tick.
  - On the tick where the counter = 1, go to UP. WAIT therefore lasts exactly D*CLKS_PER_MS cycles.
- UP entry (same edge as the WAIT exit):
  - Latch hole = random_value[log2(N_HOLES)-1:0].
  - Latch up_ms = UP_BASE_MS - level*UP_STEP_MS, computed at full width with no truncation.
  - mole_on = one-hot(hole) starting the following cycle.
  - A level change during UP does not affect the latched up_ms.
- State UP:
  - If hit[hole]=1: hit_pulse=1 for the next cycle, hit_count+1 (saturates at 255), mole_on cleared, resample the delay and go to WAIT.
  - Else, on the tick where the up counter reaches 1: miss_pulse=1, miss_count+1 (saturates at 255), mole_on cleared, resample and go to WAIT.
  - If a hit and expiry fall in the same cycle, the hit wins; no miss is recorded.
  - Hits on other holes are ignored (default build).
- enable=0 in any state:
  - Next cycle state=IDLE, mole_on=0, with no hit or miss recorded.
  - Counts hold their values; only reset clears them.
- hit_pulse and miss_pulse are never asserted together and never last more than 1 cycle.
- Inputs are sampled on the clock only.
- Buttons are level inputs. A hit held through the following WAIT window is ignored; it is judged only on cycles when the state is UP.

Optional Feature:
- Macro: MOLE_WRONG_HIT_PENALTY_EN.
- Defined: in UP, any hit bit other than hit[hole] (with hit[hole]=0 that cycle) ends the mole immediately as a miss: miss_pulse, miss_count+1, go to WAIT.
  - If the correct hole is pressed in the same cycle, it is still a hit.
- Undefined: wrong-hole presses are ignored, as described in Behaviour.

Test Plan:
Bench parameters: CLKS_PER_MS=4, UP_BASE_MS=10, UP_STEP_MS=2.
1. Reset held 3 cycles with enable=1 and hit=4'b1111 -> mole_on=0, both pulses 0, hit_count=0, miss_count=0 throughout.
2. Release reset, enable=1, random_value held at 5, level=0 -> WAIT lasts 20 cycles, then mole_on=4'b0010 (hole 1).
3. Continue from 2 with no hits -> mole_on=4'b0010 for 40 cycles, then miss_pulse for 1 cycle, miss_count=1, mole_on=0, a new 20-cycle WAIT.
4. level=3, random_value=6 (hole 2) -> up window is 16 cycles. Assert hit=4'b0100 on UP cycle 3 -> hit_pulse 1 cycle, hit_count=1, mole_on=0, no miss.
5. Assert hit[hole] exactly on the expiry cycle -> hit_pulse=1, miss_pulse stays 0, hit_count+1, miss_count unchanged.
   - Then with hit=4'b0001 while hole=2: default build shows no effect; with MOLE_WRONG_HIT_PENALTY_EN defined, miss_pulse next cycle.
6. Drop enable mid-UP -> mole_on=0 next cycle, state IDLE, counts unchanged. Assert reset mid-WAIT -> all outputs 0 next cycle. Drive 300 hits -> hit_count saturates at 255.

Source files
------------

// File: rtl/mole_scheduler.sv
// Mole scheduler: random pre-spawn delay, one-hot mole up-window, hit/miss judging and tallies.
// Optional MOLE_WRONG_HIT_PENALTY_EN: a wrong-hole press during UP ends the mole as a miss.
module mole_scheduler #(
  parameter int unsigned CLKS_PER_MS = 50000,
  parameter int unsigned VALUE_W     = 11,
  parameter int unsigned N_HOLES     = 4,
  parameter int unsigned UP_BASE_MS  = 1000,
  parameter int unsigned UP_STEP_MS  = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         level,
  input  logic [VALUE_W-1:0] random_value,
  input  logic [N_HOLES-1:0] hit,
  output logic [N_HOLES-1:0] mole_on,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [7:0]         hit_count,
  output logic [7:0]         miss_count
);

  localparam int unsigned HOLE_W = $clog2(N_HOLES);
  localparam int unsigned PS_W   = $clog2(CLKS_PER_MS + 1);
  localparam int unsigned UP_W   = $clog2(UP_BASE_MS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_UP   = 2'd2;

  logic [1:0]         r_state;
  logic [PS_W-1:0]    r_presc;
  logic [VALUE_W-1:0] r_delay;
  logic [UP_W-1:0]    r_up;
  logic [HOLE_W-1:0]  r_hole;
  logic [N_HOLES-1:0] r_mole_on;
  logic               r_hit_pulse;
  logic               r_miss_pulse;
  logic [7:0]         r_hit_count;
  logic [7:0]         r_miss_count;

  logic               w_tick;
  logic [VALUE_W-1:0] w_sample;
  logic [UP_W-1:0]    w_up_ms;
  logic [HOLE_W-1:0]  w_new_hole;
  logic               w_hit_ok;
  logic               w_expire;
  logic               w_miss;

  assign w_tick     = (r_presc == PS_W'(CLKS_PER_MS - 1));
  assign w_sample   = (random_value == '0) ? VALUE_W'(1) : random_value;
  // UP_W holds UP_BASE_MS, and the product never exceeds it, so nothing is lost here
  assign w_up_ms    = UP_W'(UP_BASE_MS) - UP_W'(level) * UP_W'(UP_STEP_MS);
  assign w_new_hole = random_value[HOLE_W-1:0];
  assign w_hit_ok   = hit[r_hole];
  assign w_expire   = w_tick && (r_up == UP_W'(1));

`ifdef MOLE_WRONG_HIT_PENALTY_EN
  logic w_wrong;
  assign w_wrong = |(hit & ~r_mole_on);
  assign w_miss  = w_expire || w_wrong;
`else
  assign w_miss  = w_expire;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_delay      <= '0;
      r_up         <= '0;
      r_hole       <= '0;
      r_mole_on    <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_presc      <= w_tick ? '0 : r_presc + PS_W'(1);
      if (!enable) begin
        r_state   <= S_IDLE;
        r_mole_on <= '0;
        r_presc   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_delay <= w_sample;
            r_presc <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (w_tick) begin
              if (r_delay <= VALUE_W'(1)) begin
                r_hole    <= w_new_hole;
                r_up      <= w_up_ms;
                r_mole_on <= N_HOLES'(1) << w_new_hole;
                r_state   <= S_UP;
              end else begin
                r_delay <= r_delay - VALUE_W'(1);
              end
            end
          end
          S_UP: begin
            // Hit is tested first so a press on the expiry cycle still counts as a hit
            if (w_hit_ok) begin
              r_hit_pulse <= 1'b1;
              if (r_hit_count != 8'hFF) r_hit_count <= r_hit_count + 8'd1;
              r_mole_on   <= '0;
              r_delay     <= w_sample;
              r_presc     <= '0;
              r_state     <= S_WAIT;
            end else if (w_miss) begin
              r_miss_pulse <= 1'b1;
              if (r_miss_count != 8'hFF) r_miss_count <= r_miss_count + 8'd1;
              r_mole_on    <= '0;
              r_delay      <= w_sample;
              r_presc      <= '0;
              r_state      <= S_WAIT;
            end else if (w_tick) begin
              r_up <= r_up - UP_W'(1);
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_mole_on <= '0;
            r_presc   <= '0;
          end
        endcase
      end
    end
  end

  assign mole_on    = r_mole_on;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_mole_scheduler.sv
// Testbench for mole_scheduler: directed scenarios plus randomized traffic against a cycle-countdown model.
module tb_mole_scheduler;

  localparam int CLKS = 4;
  localparam int NH   = 4;
  localparam int BASE = 10;
  localparam int STEP = 2;
`ifdef MOLE_WRONG_HIT_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [1:0]  level = '0;
  logic [10:0] random_value = '0;
  logic [3:0]  hit = 4'b1111;
  logic [3:0]  mole_on;
  logic        hit_pulse;
  logic        miss_pulse;
  logic [7:0]  hit_count;
  logic [7:0]  miss_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model: remaining cycles of the wait / up window; both zero means idle.
  int m_wait = 0, m_up = 0, m_hole = 0, m_hc = 0, m_mc = 0;
  bit m_hp = 0, m_mp = 0;

  mole_scheduler #(
    .CLKS_PER_MS(CLKS), .VALUE_W(11), .N_HOLES(NH), .UP_BASE_MS(BASE), .UP_STEP_MS(STEP)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .level(level),
    .random_value(random_value), .hit(hit), .mole_on(mole_on),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int delay_cycles(input int v);
    return ((v == 0) ? 1 : v) * CLKS;
  endfunction

  function automatic int exp_mole();
    return (m_up > 0) ? (1 << m_hole) : 0;
  endfunction

  task automatic model_end_up(input bit was_hit);
    if (was_hit) begin
      m_hp = 1;
      if (m_hc < 255) m_hc++;
    end else begin
      m_mp = 1;
      if (m_mc < 255) m_mc++;
    end
    m_up   = 0;
    m_wait = delay_cycles(int'(random_value));
  endtask

  task automatic model_step();
    m_hp = 0;
    m_mp = 0;
    if (reset) begin
      m_wait = 0; m_up = 0; m_hc = 0; m_mc = 0;
    end else if (!enable) begin
      m_wait = 0; m_up = 0;
    end else if (m_wait == 0 && m_up == 0) begin
      m_wait = delay_cycles(int'(random_value));
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_hole = int'(random_value) % NH;
        m_up   = (BASE - int'(level) * STEP) * CLKS;
      end
    end else begin
      if (hit[m_hole]) model_end_up(1'b1);
      else if (PEN && hit != 4'b0000) model_end_up(1'b0);
      else begin
        m_up--;
        if (m_up == 0) model_end_up(1'b0);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("mole_on", 32'(mole_on), 32'(exp_mole()));
    check("hit_pulse", 32'(hit_pulse), 32'(m_hp));
    check("miss_pulse", 32'(miss_pulse), 32'(m_mp));
    check("hit_count", 32'(hit_count), 32'(m_hc));
    check("miss_count", 32'(miss_count), 32'(m_mc));
  endtask

  task automatic run_until_mole(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (mole_on == 4'b0000 && n < max);
    if (mole_on == 4'b0000) check("mole_timeout", 32'(mole_on != 4'b0000), 32'd1);
  endtask

  initial begin
    int n, hc_s, mc_s, r;

    // 1: reset held with enable and all buttons pressed
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mole", 32'(mole_on), 32'd0);
    end

    // 2: first wait of 5 ms, hole 1
    reset = 1'b0; hit = 4'b0000; random_value = 11'd5; level = 2'd0;
    step();
    run_until_mole(100, n);
    check("wait_len", 32'(n), 32'd20);
    check("hole1", 32'(mole_on), 32'b0010);

    // 3: no hit, mole expires after 10 ms
    n = 0;
    do begin
      step();
      n++;
    end while (mole_on != 4'b0000 && n < 100);
    check("up_len", 32'(n), 32'd40);
    check("expire_miss", 32'(miss_pulse), 32'd1);
    check("miss_cnt1", 32'(miss_count), 32'd1);
    random_value = 11'd6; level = 2'd3;
    run_until_mole(100, n);
    check("wait_len2", 32'(n), 32'd20);
    check("hole2", 32'(mole_on), 32'b0100);

    // 4: hit on UP cycle 3
    step();
    step();
    hit = 4'b0100;
    step();
    hit = 4'b0000;
    check("hit_pulse4", 32'(hit_pulse), 32'd1);
    check("hit_cnt1", 32'(hit_count), 32'd1);
    check("mole_off4", 32'(mole_on), 32'd0);
    check("no_miss4", 32'(miss_pulse), 32'd0);

    // 5: hit on the expiry cycle of a 16-cycle window
    run_until_mole(100, n);
    check("wait_len3", 32'(n), 32'd24);
    for (int i = 0; i < 15; i++) step();
    check("still_up", 32'(mole_on), 32'b0100);
    hit = 4'b0100;
    step();
    hit = 4'b0000;
    check("edge_hit", 32'(hit_pulse), 32'd1);
    check("edge_nomiss", 32'(miss_pulse), 32'd0);
    check("edge_hcnt", 32'(hit_count), 32'd2);
    check("edge_mcnt", 32'(miss_count), 32'd1);
    step();
    check("edge_nomiss2", 32'(miss_pulse), 32'd0);

    // 5b: wrong-hole press
    run_until_mole(100, n);
    hit = 4'b0001;
    step();
    hit = 4'b0000;
    check("wrong_miss", 32'(miss_pulse), PEN ? 32'd1 : 32'd0);
    check("wrong_mole", 32'(mole_on), PEN ? 32'd0 : 32'b0100);

    // 6: enable drop mid-UP, then reset mid-WAIT
    if (m_up == 0) run_until_mole(100, n);
    step();
    step();
    hc_s = m_hc; mc_s = m_mc;
    enable = 1'b0;
    step();
    check("dis_mole", 32'(mole_on), 32'd0);
    check("dis_hcnt", 32'(hit_count), 32'(hc_s));
    check("dis_mcnt", 32'(miss_count), 32'(mc_s));
    for (int i = 0; i < 3; i++) step();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_w_mole", 32'(mole_on), 32'd0);
    check("rst_w_hcnt", 32'(hit_count), 32'd0);
    check("rst_w_mcnt", 32'(miss_count), 32'd0);
    check("rst_w_pulse", 32'({hit_pulse, miss_pulse}), 32'd0);

    // 6b: 300 hits saturate the hit counter
    random_value = 11'd1; level = 2'd0;
    for (int i = 0; i < 300; i++) begin
      run_until_mole(100, n);
      hit = 4'(1 << m_hole);
      step();
      hit = 4'b0000;
    end
    check("hit_sat", 32'(hit_count), 32'd255);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      enable       = ($urandom_range(0, 59) != 0);
      random_value = 11'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) level = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      if (r < 7)       hit = 4'b0000;
      else if (r < 9)  hit = 4'(1 << m_hole);
      else             hit = 4'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
